// File: rtl/jk_excitation_driver.sv
// Drives J/K of a JK flip-flop under test from a FIFO of desired next-state bits,
// holds the drive while the flop settles, then checks q_fb against the target.
module jk_excitation_driver #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

  state_t          state;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [SW-1:0]   cnt;
  logic            s;
  logic            t;
  logic            push;
  logic            pop;
  logic            empty;
  logic            head;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // s shadows the real flop; it is reloaded from q_fb at every check so a
  // faulty flop does not make later excitations drift from its true state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      s        <= 1'b0;
      t        <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b1;
      busy     <= 1'b1;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      done_cnt <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            s     <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        IDLE: begin
          if (!empty) begin
            t     <= head;
            j     <= !s && head;
            k     <= s && !head;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        CHECK: begin
          if (q_fb != t) begin
            mismatch <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
          end
          done_cnt <= done_cnt + CNT_W'(1);
          s        <= q_fb;
          j        <= 1'b0;
          k        <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: instance a drives a behavioural JK flop, instance b has q_fb
// stuck at 0 with deep settle and 2-bit counters for fill/saturation cases.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[2];
  logic in_valid[2];
  logic in_bit[2];
  logic in_ready[2];
  logic j[2];
  logic k[2];
  logic busy[2];
  logic mismatch[2];
  logic [7:0] err_a, done_a;
  logic [1:0] err_b, done_b;
  logic q_fb_a, q_fb_b;
  logic q_model = 1'b0;
  logic stuck_a = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb_a[$];
  logic [2:0] sb_b[$];
  int         prev_done[2];
  int         exp_err[2];
  int         exp_done[2];
  logic [1:0] last_jk[2];

  assign q_fb_a = stuck_a ? 1'b0 : q_model;
  assign q_fb_b = 1'b0;

  always @(posedge clk) begin
    case ({j[0], k[0]})
      2'b10:   q_model <= 1'b1;
      2'b01:   q_model <= 1'b0;
      2'b11:   q_model <= ~q_model;
      default: q_model <= q_model;
    endcase
  end

  jk_excitation_driver #(.DEPTH(4), .SETTLE(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
    .in_ready(in_ready[0]), .j(j[0]), .k(k[0]), .q_fb(q_fb_a), .busy(busy[0]),
    .mismatch(mismatch[0]), .err_cnt(err_a), .done_cnt(done_a)
  );

  jk_excitation_driver #(.DEPTH(4), .SETTLE(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
    .in_ready(in_ready[1]), .j(j[1]), .k(k[1]), .q_fb(q_fb_b), .busy(busy[1]),
    .mismatch(mismatch[1]), .err_cnt(err_b), .done_cnt(done_b)
  );

  function automatic logic [31:0] err_of(int sel);
    return (sel != 0) ? {30'b0, err_b} : {24'b0, err_a};
  endfunction

  function automatic logic [31:0] done_of(int sel);
    return (sel != 0) ? {30'b0, done_b} : {24'b0, done_a};
  endfunction

  function automatic int sb_size(int sel);
    return (sel != 0) ? sb_b.size() : sb_a.size();
  endfunction

  function automatic string tag(int sel, string name);
    return $sformatf("%s_%s", (sel != 0) ? "b" : "a", name);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a change of done_cnt marks a completed check; pop and compare it.
  task automatic monitor_step(int sel);
    logic [2:0]  e;
    logic [31:0] d;
    int          max_err;
    int          modulus;
    max_err = (sel != 0) ? 3 : 255;
    modulus = (sel != 0) ? 4 : 256;
    d = done_of(sel);
    if (rst[sel] === 1'b1) begin
      prev_done[sel] = 0;
      exp_err[sel]   = 0;
      exp_done[sel]  = 0;
    end else if (d != 32'(prev_done[sel])) begin
      if (sb_size(sel) == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: got done_cnt %0d expected no check pending", tag(sel, "unexpected_check"), d);
      end else begin
        e = (sel != 0) ? sb_b.pop_front() : sb_a.pop_front();
        checkOutput(tag(sel, "jk"), {30'b0, last_jk[sel]}, {30'b0, e[2:1]});
        checkOutput(tag(sel, "mismatch"), {31'b0, mismatch[sel]}, {31'b0, e[0]});
        if (e[0] && exp_err[sel] != max_err) exp_err[sel]++;
        exp_done[sel] = (exp_done[sel] + 1) % modulus;
        checkOutput(tag(sel, "err_cnt"), err_of(sel), 32'(exp_err[sel]));
        checkOutput(tag(sel, "done_cnt"), d, 32'(exp_done[sel]));
      end
      prev_done[sel] = int'(d);
    end else if (mismatch[sel] === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got mismatch 1 expected 0 outside a check", tag(sel, "stray_mismatch"));
    end
    last_jk[sel] = {j[sel], k[sel]};
  endtask

  always @(negedge clk) monitor_step(0);
  always @(negedge clk) monitor_step(1);

  // Push one target bit (waiting for in_ready) and queue its expected {j,k,mismatch}.
  task automatic applyStimulus(int sel, logic b, logic [2:0] exp);
    int n;
    in_valid[sel] = 1'b1;
    in_bit[sel]   = b;
    n = 0;
    while (in_ready[sel] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checkOutput(tag(sel, "push_timeout"), 32'(n), 32'd0);
    end else begin
      @(posedge clk);
      if (sel != 0) sb_b.push_back(exp);
      else sb_a.push_back(exp);
      #1;
    end
    in_valid[sel] = 1'b0;
  endtask

  // Call mid-cycle; returns 1 time unit after the first rising edge out of reset.
  task automatic do_reset(int sel);
    rst[sel]      = 1'b1;
    in_valid[sel] = 1'b0;
    if (sel != 0) sb_b.delete();
    else sb_a.delete();
    #1;
    checkOutput(tag(sel, "rst_jk"), {30'b0, j[sel], k[sel]}, 32'b01);
    checkOutput(tag(sel, "rst_busy"), {31'b0, busy[sel]}, 32'd1);
    checkOutput(tag(sel, "rst_ready"), {31'b0, in_ready[sel]}, 32'd1);
    checkOutput(tag(sel, "rst_mismatch"), {31'b0, mismatch[sel]}, 32'd0);
    checkOutput(tag(sel, "rst_err"), err_of(sel), 32'd0);
    checkOutput(tag(sel, "rst_done"), done_of(sel), 32'd0);
    @(posedge clk);
    #1;
    rst[sel] = 1'b0;
  endtask

  task automatic wait_drain(int sel);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb_size(sel) == 0 && busy[sel] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(tag(sel, "drain_timeout"), 32'(sb_size(sel)), 32'd0);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       fill_bits[6];
    logic [2:0] fill_exp[6];
    logic       rdy;
    int         accepted;

    rst[0] = 1'b0;      rst[1] = 1'b1;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    in_bit[0] = 1'b0;   in_bit[1] = 1'b0;

    // Async reset, then the SETTLE-cycle clear before idle.
    @(posedge clk);
    #3;
    do_reset(0);
    checkOutput("a_init_busy_1", {31'b0, busy[0]}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("a_init_busy_2", {31'b0, busy[0]}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("a_idle_busy", {31'b0, busy[0]}, 32'd0);
    checkOutput("a_idle_jk", {30'b0, j[0], k[0]}, 32'b00);

    // Correct flop: targets 1,1,0,0,1.
    applyStimulus(0, 1'b1, 3'b100);
    applyStimulus(0, 1'b1, 3'b000);
    applyStimulus(0, 1'b0, 3'b010);
    applyStimulus(0, 1'b0, 3'b000);
    applyStimulus(0, 1'b1, 3'b100);
    wait_drain(0);
    checkOutput("a_seq_done", {24'b0, done_a}, 32'd5);
    checkOutput("a_seq_err", {24'b0, err_a}, 32'd0);

    // Fault: q_fb stuck at 0; shadow resyncs so both drives are set.
    @(posedge clk);
    #3;
    stuck_a = 1'b1;
    do_reset(0);
    applyStimulus(0, 1'b1, 3'b101);
    applyStimulus(0, 1'b1, 3'b101);
    wait_drain(0);
    checkOutput("a_fault_err", {24'b0, err_a}, 32'd2);
    checkOutput("a_fault_done", {24'b0, done_a}, 32'd2);
    stuck_a = 1'b0;

    // Reset while in DRIVE with three bits queued.
    @(posedge clk);
    #3;
    do_reset(0);
    applyStimulus(0, 1'b1, 3'b100);
    applyStimulus(0, 1'b0, 3'b010);
    applyStimulus(0, 1'b1, 3'b100);
    applyStimulus(0, 1'b0, 3'b010);
    checkOutput("a_mid_busy", {31'b0, busy[0]}, 32'd1);
    checkOutput("a_mid_jk", {30'b0, j[0], k[0]}, 32'b10);
    #2;
    do_reset(0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("a_after_busy", {31'b0, busy[0]}, 32'd0);
    checkOutput("a_after_done", {24'b0, done_a}, 32'd0);
    checkOutput("a_after_err", {24'b0, err_a}, 32'd0);

    // Fill FIFO of b while its long INIT stalls the drain.
    fill_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    fill_exp  = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b000, 3'b000};
    @(posedge clk);
    #3;
    do_reset(1);
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid[1] = 1'b1;
      in_bit[1]   = fill_bits[i];
      rdy = in_ready[1];
      if (i == 4) checkOutput("b_ready_after4", {31'b0, rdy}, 32'd0);
      @(posedge clk);
      if (rdy === 1'b1) begin
        sb_b.push_back(fill_exp[i]);
        accepted++;
      end
      #1;
    end
    in_valid[1] = 1'b0;
    checkOutput("b_accepted", 32'(accepted), 32'd4);
    wait_drain(1);
    checkOutput("b_fill_err", {30'b0, err_b}, 32'd2);
    checkOutput("b_fill_done", {30'b0, done_b}, 32'd0);

    // Saturating err_cnt and wrapping done_cnt at 2 bits.
    @(posedge clk);
    #3;
    do_reset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, 3'b101);
    wait_drain(1);
    checkOutput("b_sat_err", {30'b0, err_b}, 32'd3);
    checkOutput("b_wrap_done", {30'b0, done_b}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_sb_empty", 32'(sb_a.size()), 32'd0);
    checkOutput("b_sb_empty", 32'(sb_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
